// File: rtl/rw_step_sequencer.sv
// rw_step_sequencer: steps a ReWire resumption core under a valid/ready handshake.
// Owns the {tag,state} register, registers each step result and halts on
// termination (core_cont==0) until restart.
// Optional feature macro: RW_STEP_COUNT_EN (accepted-step counter; tied to 0 when undefined).
module rw_step_sequencer #(
    parameter int unsigned     IN_W        = 1,
    parameter int unsigned     OUT_W       = 1,
    parameter int unsigned     ST_W        = 2,
    parameter logic [ST_W-1:0] RESET_STATE = 2'h2,
    parameter int unsigned     CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    input  logic             restart,
    output logic             halted,
    output logic [CNT_W-1:0] step_count,
    output logic [IN_W-1:0]  core_in,
    output logic [ST_W-1:0]  core_state,
    input  logic             core_cont,
    input  logic [OUT_W-1:0] core_out,
    input  logic [ST_W-1:0]  core_next
);

    typedef enum logic {RUN, HALT} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [ST_W-1:0]  state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             accept;

    assign core_in    = in_data;
    assign core_state = state_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign halted     = (fsm_q == HALT);

    // Accept a step only while running, not restarting, and with room in the output register.
    always_comb begin
        in_ready = 1'b0;
        if (!rst && !restart && fsm_q == RUN)
            in_ready = !out_valid_q || out_ready;
    end

    assign accept = in_valid && in_ready;

    // Next-state: restart dominates, then accept, then output drain.
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (restart) begin
            fsm_d       = RUN;
            state_d     = RESET_STATE;
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_data_d  = core_out;
            out_valid_d = 1'b1;
            if (core_cont)
                state_d = core_next;
            else
                fsm_d = HALT;
        end else if (out_ready && out_valid_q) begin
            out_valid_d = 1'b0;
        end
    end

    // Core/FSM/output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= RUN;
            state_q     <= RESET_STATE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef RW_STEP_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of accepted steps, cleared by restart.
    always_comb begin
        cnt_d = cnt_q;
        if (restart)
            cnt_d = '0;
        else if (accept && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
    end

    // Step counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign step_count = cnt_q;
`else
    assign step_count = '0;
`endif

endmodule

// File: tb/tb_rw_step_sequencer.sv
// Directed bench for rw_step_sequencer with a stub core: next=state^1,
// out=state[0]^in, cont driven by the bench.
module tb_rw_step_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_data;
    logic        out_valid, out_ready, out_data;
    logic        restart, halted;
    logic [15:0] step_count;
    logic        core_in, core_cont, core_out;
    logic [1:0]  core_state, core_next;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign core_next = core_state ^ 2'b01;
    assign core_out  = core_state[0] ^ core_in;

    rw_step_sequencer #(
        .IN_W(1), .OUT_W(1), .ST_W(2), .RESET_STATE(2'h2), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .restart(restart), .halted(halted), .step_count(step_count),
        .core_in(core_in), .core_state(core_state), .core_cont(core_cont),
        .core_out(core_out), .core_next(core_next)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int n);
`ifdef RW_STEP_COUNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 1'b0; out_ready = 1'b0;
        restart = 1'b0; core_cont = 1'b1;
        #2;
        check("rst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_state", core_state, 2);
        check("rst_out_valid", out_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_in_ready_after", in_ready, 1);
        check("rst_count", step_count, cnt_exp(0));

        // Back-to-back: state 2->3->2->3->2, outputs 1,0,1,0
        in_valid = 1'b1; out_ready = 1'b1; in_data = 1'b1;
        tick(); check("b2b1_data", out_data, 1); check("b2b1_state", core_state, 3); check("b2b1_valid", out_valid, 1);
        tick(); check("b2b2_data", out_data, 0); check("b2b2_state", core_state, 2); check("b2b2_valid", out_valid, 1);
        tick(); check("b2b3_data", out_data, 1); check("b2b3_state", core_state, 3); check("b2b3_valid", out_valid, 1);
        tick(); check("b2b4_data", out_data, 0); check("b2b4_state", core_state, 2); check("b2b4_valid", out_valid, 1);
        check("b2b_count", step_count, cnt_exp(4));
        in_valid = 1'b0;
        tick(); check("drain_valid", out_valid, 0);

        // Backpressure
        out_ready = 1'b0; in_valid = 1'b1; in_data = 1'b0;
        tick();
        check("bp_data", out_data, 0); check("bp_state", core_state, 3);
        check("bp_in_ready", in_ready, 0); check("bp_valid", out_valid, 1);
        in_data = 1'b1;
        tick();
        check("bp_hold_data", out_data, 0); check("bp_hold_state", core_state, 3);
        check("bp_hold_count", step_count, cnt_exp(5));
        out_ready = 1'b1; in_data = 1'b0;
        #1 check("bp_release_ready", in_ready, 1);
        tick();
        check("bp_next_data", out_data, 1); check("bp_next_state", core_state, 2);
        check("bp_next_valid", out_valid, 1); check("bp_next_count", step_count, cnt_exp(6));
        in_valid = 1'b0;
        tick(); check("bp_drain", out_valid, 0);

        // Restart then terminate on step 3
        restart = 1'b1;
        tick();
        check("rs_count", step_count, cnt_exp(0)); check("rs_state", core_state, 2);
        restart = 1'b0; in_valid = 1'b1; in_data = 1'b0; core_cont = 1'b1;
        tick(); check("h1_data", out_data, 0); check("h1_state", core_state, 3);
        tick(); check("h2_data", out_data, 1); check("h2_state", core_state, 2);
        core_cont = 1'b0;
        tick();
        check("h3_data", out_data, 0); check("h3_valid", out_valid, 1);
        check("h3_halted", halted, 1); check("h3_in_ready", in_ready, 0);
        check("h3_state", core_state, 2); check("h3_count", step_count, cnt_exp(3));
        core_cont = 1'b1;
        tick();
        check("hd_valid", out_valid, 0); check("hd_halted", halted, 1);
        check("hd_state", core_state, 2); check("hd_count", step_count, cnt_exp(3));

        // Restart while halted with in_valid high
        restart = 1'b1;
        #1 check("hr_in_ready", in_ready, 0);
        tick();
        check("hr_state", core_state, 2); check("hr_halted", halted, 0);
        check("hr_count", step_count, cnt_exp(0)); check("hr_valid", out_valid, 0);
        restart = 1'b0;

        // Async reset between edges with pending output
        tick();
        check("ar_pre_valid", out_valid, 1); check("ar_pre_state", core_state, 3);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("ar_valid", out_valid, 0); check("ar_state", core_state, 2);
        check("ar_in_ready", in_ready, 0); check("ar_count", step_count, 0);
        check("ar_data", out_data, 0);
        tick();
        rst = 1'b0;
        #1 check("ar_release_ready", in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
